axi_burst_reader: RTL and testbench



---
 rtl/axi_burst_reader.sv | 142 ++++++++++++++
 tb/tb_axi_burst_reader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: splits a (start address, word count) command into
// 4 KB-safe INCR bursts and streams the returned words out in order.
module axi_burst_reader #(
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [6:0]  ARID_VAL        = 7'd0
) (
  input  logic        s_aclk,
  input  logic        s_areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_words,
  output logic [6:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [6:0]  m_axi_rid,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        done,
  output logic        err
);
  localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);
  localparam logic [3:0]  MAX_OUT_W   = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;
  state_t state, state_nxt;

  logic [31:0] addr_q;
  logic [15:0] rem_ar;
  logic [15:0] rem_r;
  logic [3:0]  outstanding;
  logic [7:0]  arlen_q;
  logic [8:0]  beats;
  logic [31:0] addr_step;
  logic [15:0] rem_ar_step;
  logic [31:0] cmd_addr_al;
  logic        cmd_hs;
  logic        ar_hs;
  logic        r_hs;
  logic        rlast_hs;
  logic        unused_bits;

  function automatic logic [8:0] burst_beats(input logic [31:0] a, input logic [15:0] rem);
    logic [10:0] bound;
    logic [15:0] b;
    bound = 11'd1024 - {1'b0, a[11:2]};
    b = (rem > MAX_BURST_W) ? MAX_BURST_W : rem;
    if ({5'd0, bound} < b) b = {5'd0, bound};
    return 9'(b);
  endfunction

  function automatic logic [7:0] len_of(input logic [8:0] n);
    return (n == 9'd0) ? 8'd0 : 8'(n - 9'd1);
  endfunction

  assign unused_bits   = ^{m_axi_rid, cmd_addr[1:0]};
  assign cmd_addr_al   = {cmd_addr[31:2], 2'b00};

  assign m_axi_arid    = ARID_VAL;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;

  assign cmd_ready     = (state == IDLE);
  assign done          = (state == FIN);
  assign cmd_hs        = (state == IDLE) && cmd_valid;

  assign beats         = burst_beats(addr_q, rem_ar);
  assign addr_step     = addr_q + {21'd0, beats, 2'b00};
  assign rem_ar_step   = rem_ar - {7'd0, beats};
  assign m_axi_arvalid = (state == BUSY) && (rem_ar != 16'd0) && (outstanding < MAX_OUT_W);
  assign ar_hs         = m_axi_arvalid && m_axi_arready;

  assign m_axi_rready  = (state == BUSY) && out_ready;
  assign out_valid     = (state == BUSY) && m_axi_rvalid;
  assign out_data      = m_axi_rdata;
  assign out_last      = out_valid && (rem_r == 16'd1);
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign rlast_hs      = r_hs && m_axi_rlast;

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = (cmd_words == 16'd0) ? FIN : BUSY;
      BUSY:    if (r_hs && (rem_r == 16'd1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // arlen is precomputed from the post-update address/count so the AR
  // payload is a plain register that cannot move while arvalid waits.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      addr_q      <= '0;
      rem_ar      <= '0;
      rem_r       <= '0;
      outstanding <= '0;
      arlen_q     <= '0;
      err         <= 1'b0;
    end else if (cmd_hs) begin
      addr_q  <= cmd_addr_al;
      rem_ar  <= cmd_words;
      rem_r   <= cmd_words;
      arlen_q <= len_of(burst_beats(cmd_addr_al, cmd_words));
      err     <= 1'b0;
    end else begin
      if (ar_hs) begin
        addr_q  <= addr_step;
        rem_ar  <= rem_ar_step;
        arlen_q <= len_of(burst_beats(addr_step, rem_ar_step));
      end
      if (r_hs) begin
        rem_r <= rem_r - 16'd1;
        if (m_axi_rresp != 2'b00) err <= 1'b1;
      end
      case ({ar_hs, rlast_hs})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader: randomized AXI slave plus a command-level
// reference model checked against the DUT outputs every cycle.
module tb_axi_burst_reader;
  localparam int         MAXB = 16;
  localparam int         MAXO = 4;
  localparam logic [6:0] ARID = 7'h2A;

  logic        s_aclk;
  logic        s_areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_words;
  logic [6:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [6:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        done;
  logic        err;

  axi_burst_reader #(
    .MAX_BURST(MAXB),
    .MAX_OUTSTANDING(MAXO),
    .ARID_VAL(ARID)
  ) dut (
    .s_aclk(s_aclk), .s_areset(s_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .done(done), .err(err)
  );

  initial s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  int total = 0;
  int bad   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory content: every word is a fixed function of its byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          beats;
  } burst_t;
  typedef burst_t burst_q_t[$];

  // Expected burst list: greedy split by remaining count, burst cap and 4 KB room.
  function automatic burst_q_t plan(input logic [31:0] a0, input int n);
    burst_q_t q;
    longint a, room, b, left;
    a = longint'({a0[31:2], 2'b00});
    left = n;
    while (left > 0) begin
      room = (4096 - (a % 4096)) / 4;
      b = (left < MAXB) ? left : MAXB;
      if (room < b) b = room;
      q.push_back('{addr: a[31:0], beats: int'(b)});
      a = (a + 4 * b) & 64'hFFFF_FFFF;
      left -= b;
    end
    return q;
  endfunction

  // Slave knobs (percent probabilities) and state shared with the main sequence.
  int ar_pct   = 100;
  int r_pct    = 100;
  int ordy_pct = 100;
  int err_at   = -1;
  int cmd_beat = 0;

  initial begin : slave
    burst_t      sq[$];
    int          sbeat;
    logic        s_ar, s_r;
    logic [31:0] cap_addr, a;
    logic [7:0]  cap_len;
    sbeat = 0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rid     = '0;
    out_ready     = 1'b0;
    forever begin
      @(negedge s_aclk);
      s_ar     = !s_areset && m_axi_arvalid && m_axi_arready;
      s_r      = !s_areset && m_axi_rvalid && m_axi_rready;
      cap_addr = m_axi_araddr;
      cap_len  = m_axi_arlen;
      @(posedge s_aclk);
      #1;
      if (s_areset) begin
        sq.delete();
        sbeat = 0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_arready = 1'b0;
        continue;
      end
      if (s_ar) sq.push_back('{addr: cap_addr, beats: int'(cap_len) + 1});
      if (s_r) begin
        m_axi_rvalid = 1'b0;
        sbeat++;
        cmd_beat++;
        if (sq.size() > 0 && sbeat >= sq[0].beats) begin
          void'(sq.pop_front());
          sbeat = 0;
        end
      end
      m_axi_arready = ($urandom_range(99, 0) < ar_pct);
      out_ready     = ($urandom_range(99, 0) < ordy_pct);
      if (!m_axi_rvalid && sq.size() > 0 && $urandom_range(99, 0) < r_pct) begin
        a = sq[0].addr + 32'(4 * sbeat);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_word(a);
        m_axi_rlast  = (sbeat == sq[0].beats - 1);
        m_axi_rresp  = (cmd_beat == err_at) ? 2'b10 : 2'b00;
        m_axi_rid    = 7'($urandom);
      end
    end
  end

  // Reference model, advanced once per cycle from the handshakes seen.
  typedef enum {M_IDLE, M_BUSY, M_FIN} phase_t;
  phase_t      ph;
  burst_q_t    mb;
  burst_t      ar_log[$];
  int          ar_idx, outst, m_beat, m_words;
  logic [31:0] m_base;
  logic        m_err;

  initial begin : compare
    logic        busy, exp_arv, ar_hs, r_hs, prev_stall;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    ph = M_IDLE; ar_idx = 0; outst = 0; m_beat = 0; m_words = 0; m_base = '0; m_err = 1'b0;
    prev_stall = 1'b0; prev_addr = '0; prev_len = '0;
    forever begin
      @(negedge s_aclk);
      if (s_areset) begin
        ph = M_IDLE; mb.delete(); ar_idx = 0; outst = 0; m_beat = 0; m_words = 0; m_err = 1'b0;
        prev_stall = 1'b0;
        continue;
      end
      busy = (ph == M_BUSY);
      check1("cmd_ready", cmd_ready, ph == M_IDLE);
      check1("done", done, ph == M_FIN);
      check1("err", err, m_err);
      exp_arv = busy && (ar_idx < mb.size()) && (outst < MAXO);
      check1("arvalid", m_axi_arvalid, exp_arv);
      if (m_axi_arvalid && exp_arv) begin
        check32("araddr", m_axi_araddr, mb[ar_idx].addr);
        check32("arlen", 32'(m_axi_arlen), 32'(mb[ar_idx].beats - 1));
      end
      if (prev_stall) begin
        check1("arvalid_held", m_axi_arvalid, 1'b1);
        check32("araddr_held", m_axi_araddr, prev_addr);
        check32("arlen_held", 32'(m_axi_arlen), 32'(prev_len));
      end
      check1("rready", m_axi_rready, busy && out_ready);
      check1("out_valid", out_valid, busy && m_axi_rvalid);
      if (out_valid) begin
        check32("out_data_pass", out_data, m_axi_rdata);
        check1("out_last", out_last, m_beat == m_words - 1);
      end else begin
        check1("out_last_idle", out_last, 1'b0);
      end

      ar_hs      = m_axi_arvalid && m_axi_arready;
      r_hs       = m_axi_rvalid && m_axi_rready;
      prev_stall = m_axi_arvalid && !m_axi_arready;
      prev_addr  = m_axi_araddr;
      prev_len   = m_axi_arlen;
      case (ph)
        M_IDLE: if (cmd_valid) begin
          m_base  = {cmd_addr[31:2], 2'b00};
          m_words = int'(cmd_words);
          mb      = plan(cmd_addr, int'(cmd_words));
          ar_idx  = 0; outst = 0; m_beat = 0; m_err = 1'b0;
          ph      = (m_words == 0) ? M_FIN : M_BUSY;
        end
        M_FIN: ph = M_IDLE;
        default: begin
          if (ar_hs) begin
            ar_log.push_back('{addr: m_axi_araddr, beats: int'(m_axi_arlen) + 1});
            ar_idx++;
            outst++;
          end
          if (r_hs) begin
            check32("data_in_order", out_data, mem_word(m_base + 32'(4 * m_beat)));
            if (m_axi_rresp != 2'b00) m_err = 1'b1;
            if (m_axi_rlast) outst--;
            m_beat++;
            if (m_beat == m_words) ph = M_FIN;
          end
        end
      endcase
    end
  end

  task automatic start_cmd(input logic [31:0] a, input int n);
    @(posedge s_aclk);
    #1;
    cmd_addr  = a;
    cmd_words = 16'(n);
    cmd_valid = 1'b1;
    cmd_beat  = 0;
    @(posedge s_aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge s_aclk);
      if (done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    check1("done_within_budget", seen, 1'b1);
  endtask

  task automatic check_ar(input int idx, input logic [31:0] a, input int n);
    if (idx < ar_log.size()) begin
      check32("ar_log_addr", ar_log[idx].addr, a);
      check32("ar_log_beats", 32'(ar_log[idx].beats), 32'(n));
    end else begin
      check32("ar_log_size", 32'(ar_log.size()), 32'(idx + 1));
    end
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    burst_q_t    p;
    int          lat, n;
    logic [31:0] a;
    s_areset  = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_words = '0;
    #2;
    check1("rst_cmd_ready", cmd_ready, 1'b1);
    check1("rst_arvalid", m_axi_arvalid, 1'b0);
    check32("rst_araddr", m_axi_araddr, 32'h0);
    check32("rst_arlen", 32'(m_axi_arlen), 32'h0);
    check1("rst_rready", m_axi_rready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_out_last", out_last, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("arid", 32'(m_axi_arid), 32'(ARID));
    check32("arsize", 32'(m_axi_arsize), 32'h2);
    check32("arburst", 32'(m_axi_arburst), 32'h1);

    p = plan(32'h0000_0100, 40);
    check32("plan1_size", 32'(p.size()), 32'd3);
    if (p.size() == 3) begin
      check32("plan1_a2", p[2].addr, 32'h180);
      check32("plan1_b2", 32'(p[2].beats), 32'd8);
    end
    p = plan(32'h0000_0FF0, 8);
    check32("plan2_size", 32'(p.size()), 32'd2);
    if (p.size() == 2) check32("plan2_a1", p[1].addr, 32'h1000);

    repeat (2) @(posedge s_aclk);
    #2;
    s_areset = 1'b0;

    ar_log.delete();
    start_cmd(32'h0000_0100, 40);
    wait_done(2000, lat);
    check32("t1_beats", 32'(m_beat), 32'd40);
    check32("t1_ar_count", 32'(ar_log.size()), 32'd3);
    check_ar(0, 32'h100, 16);
    check_ar(1, 32'h140, 16);
    check_ar(2, 32'h180, 8);
    check1("t1_err", err, 1'b0);

    ar_log.delete();
    start_cmd(32'h0000_0FF0, 8);
    wait_done(2000, lat);
    check_ar(0, 32'h0FF0, 4);
    check_ar(1, 32'h1000, 4);

    ar_log.delete();
    start_cmd(32'hFFFF_FFF3, 8);
    wait_done(2000, lat);
    check_ar(0, 32'hFFFF_FFF0, 4);
    check_ar(1, 32'h0000_0000, 4);

    ar_log.delete();
    start_cmd(32'h0000_0500, 0);
    wait_done(10, lat);
    check32("t3_done_latency", 32'(lat), 32'd0);
    @(negedge s_aclk);
    check1("t3_cmd_ready_back", cmd_ready, 1'b1);
    check32("t3_no_ar", 32'(ar_log.size()), 32'd0);

    ar_log.delete();
    r_pct = 0;
    start_cmd(32'h0000_4000, 128);
    repeat (10) @(negedge s_aclk);
    check32("t4_ar_count_full", 32'(ar_log.size()), 32'd4);
    check1("t4_arvalid_blocked", m_axi_arvalid, 1'b0);
    ar_pct = 0;
    r_pct  = 100;
    repeat (40) @(negedge s_aclk);
    check32("t4_ar_count_stalled", 32'(ar_log.size()), 32'd4);
    check1("t4_arvalid_waiting", m_axi_arvalid, 1'b1);
    check32("t4_araddr_waiting", m_axi_araddr, 32'h0000_4100);
    check32("t4_arlen_waiting", 32'(m_axi_arlen), 32'd15);
    ar_pct = 100;
    wait_done(3000, lat);
    check32("t4_ar_total", 32'(ar_log.size()), 32'd8);

    ar_pct = 70; r_pct = 80; ordy_pct = 50;
    start_cmd(32'h0000_2FC0, 100);
    wait_done(5000, lat);
    check32("t5_beats", 32'(m_beat), 32'd100);

    ar_pct = 100; r_pct = 100; ordy_pct = 100; err_at = 2;
    start_cmd(32'h0000_3000, 10);
    wait_done(2000, lat);
    check1("t6_err_sticky", err, 1'b1);
    err_at = -1;
    start_cmd(32'h0000_3100, 5);
    wait_done(2000, lat);
    check1("t6_err_cleared", err, 1'b0);

    r_pct = 60;
    start_cmd(32'h0000_5000, 200);
    repeat (12) @(negedge s_aclk);
    @(posedge s_aclk);
    #3;
    s_areset = 1'b1;
    #1;
    check1("t7_arvalid", m_axi_arvalid, 1'b0);
    check1("t7_cmd_ready", cmd_ready, 1'b1);
    check1("t7_rready", m_axi_rready, 1'b0);
    check1("t7_done", done, 1'b0);
    check32("t7_araddr", m_axi_araddr, 32'h0);
    repeat (2) @(posedge s_aclk);
    #2;
    s_areset = 1'b0;
    r_pct = 100;
    ar_log.delete();
    start_cmd(32'h0000_2000, 70);
    wait_done(2000, lat);
    check32("t7_after_beats", 32'(m_beat), 32'd70);
    check32("t7_after_ar_count", 32'(ar_log.size()), 32'd5);

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(300, 1));
      a = $urandom;
      if ($urandom_range(1, 0) == 1) a[11:0] = 12'(4096 - 4 * int'($urandom_range(20, 1)));
      ar_pct   = int'($urandom_range(100, 40));
      r_pct    = int'($urandom_range(100, 40));
      ordy_pct = int'($urandom_range(100, 40));
      err_at   = int'($urandom_range(400, 0));
      start_cmd(a, n);
      wait_done(500 + n * 30, lat);
      check32("rand_beats", 32'(m_beat), 32'(n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
